// File: rtl/max_tracker_pkg.sv
// Shared widths, limits and FSM encoding for the running-maximum tracker.
package max_tracker_pkg;

    localparam int DATA_W  = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_MAXED = 2'd2;

    // Counters stick at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(CNT_MAX)) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/max_tracker_cmp2.sv
// Combinational 2-bit unsigned magnitude comparator: GT = (A > B), EQ = (A == B).
module cmp2
    import max_tracker_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              GT,
    output logic              EQ
);

    assign GT = (A > B);
    assign EQ = (A == B);

endmodule

// File: rtl/max_tracker.sv
// Tracks the largest accepted sample, how often it has been seen and how many
// samples arrived since reset/clear. All outputs come straight from flops.
module max_tracker
    import max_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic [DATA_W-1:0] max_val,
    output logic              max_valid,
    output logic              new_max,
    output logic [CNT_W-1:0]  eq_count,
    output logic [CNT_W-1:0]  sample_count
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] max_val_q, max_val_d;
    logic              max_valid_q, max_valid_d;
    logic              new_max_q, new_max_d;
    logic [CNT_W-1:0]  eq_count_q, eq_count_d;
    logic [CNT_W-1:0]  sample_count_q, sample_count_d;
    logic              gt, eq;

    cmp2 u_cmp (
        .A  (in_data),
        .B  (max_val_q),
        .GT (gt),
        .EQ (eq)
    );

    always_comb begin
        state_d        = state_q;
        max_val_d      = max_val_q;
        eq_count_d     = eq_count_q;
        sample_count_d = sample_count_q;
        new_max_d      = 1'b0;

        if (clear) begin
            // The sample offered alongside clear is dropped.
            state_d        = ST_EMPTY;
            max_val_d      = '0;
            eq_count_d     = '0;
            sample_count_d = '0;
        end else if (in_valid) begin
            case (state_q)
                ST_EMPTY: begin
                    max_val_d      = in_data;
                    eq_count_d     = CNT_W'(1);
                    sample_count_d = CNT_W'(1);
                    new_max_d      = 1'b1;
                    state_d        = (&in_data) ? ST_MAXED : ST_TRACK;
                end
                default: begin
                    sample_count_d = sat_inc(sample_count_q);
                    if (gt) begin
                        max_val_d  = in_data;
                        eq_count_d = CNT_W'(1);
                        new_max_d  = 1'b1;
                        state_d    = (&in_data) ? ST_MAXED : ST_TRACK;
                    end else if (eq) begin
                        eq_count_d = sat_inc(eq_count_q);
                    end
                end
            endcase
        end

        max_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            max_val_q      <= '0;
            max_valid_q    <= 1'b0;
            new_max_q      <= 1'b0;
            eq_count_q     <= '0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            max_val_q      <= max_val_d;
            max_valid_q    <= max_valid_d;
            new_max_q      <= new_max_d;
            eq_count_q     <= eq_count_d;
            sample_count_q <= sample_count_d;
        end
    end

    assign max_val      = max_val_q;
    assign max_valid    = max_valid_q;
    assign new_max      = new_max_q;
    assign eq_count     = eq_count_q;
    assign sample_count = sample_count_q;

endmodule

// File: doc/max_tracker.md
MAX_TRACKER -- requirements
Module: max_tracker

Interface
REQ-001 SHALL have no parameters; data width is fixed at 2 bits and counter width at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data is a sample this cycle.
REQ-005 in_data  input  2  unsigned sample, 0..3.
REQ-006 clear  input  1  synchronous restart of tracking.
REQ-007 max_val  output  2  largest sample accepted since reset/clear.
REQ-008 max_valid  output  1  at least one sample accepted since reset/clear.
REQ-009 new_max  output  1  one-cycle pulse: max_val changed on the last edge.
REQ-010 eq_count  output  4  accepted samples equal to current max_val, saturating at 15.
REQ-011 sample_count  output  4  total accepted samples, saturating at 15.

Function
REQ-012 All outputs SHALL be registered, so a sample accepted at edge N is reflected at edge N.
REQ-013 The FSM SHALL have three states: EMPTY (no sample), TRACK (max_val < 3), MAXED (max_val = 3).
REQ-014 A sample SHALL be compared as A = in_data, B = max_val using the GT/EQ comparator sub-module.
REQ-015 EMPTY with in_valid: max_val <= in_data, eq_count <= 1, sample_count <= 1, new_max <= 1, and next state is MAXED if in_data = 3, else TRACK.
REQ-016 TRACK with in_valid and GT: max_val <= in_data, eq_count <= 1, new_max <= 1, and next state is MAXED if in_data = 3.
REQ-017 TRACK or MAXED with in_valid and EQ: eq_count increments, saturating at 15, and new_max <= 0.
REQ-018 TRACK or MAXED with in_valid, GT = 0 and EQ = 0: max_val and eq_count hold, and new_max <= 0.
REQ-019 Every accepted sample SHALL increment sample_count, saturating at 15; eq_count and sample_count never wrap.
REQ-020 When in_valid is 0, all state SHALL hold and new_max <= 0.
REQ-021 max_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-022 clear = 1 SHALL take priority over in_valid: the sample in that cycle is dropped and all outputs return to their reset values at the next edge.
REQ-023 rst SHALL take priority over clear and in_valid.

Reset
REQ-024 rst = 1 at an edge SHALL force state EMPTY, max_val = 0, max_valid = 0, new_max = 0, eq_count = 0 and sample_count = 0.
REQ-025 Asserting rst mid-stream SHALL discard all history, with no partial update from the concurrent sample.
REQ-026 Asynchronous reset behaviour is not permitted.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (EMPTY = 2'd0, TRACK = 2'd1, MAXED = 2'd2), DATA_W = 2, CNT_W = 4 and CNT_MAX = 15.
REQ-028 The block SHALL instantiate exactly one sub-module, cmp2: a purely combinational 2-bit magnitude comparator with ports A, B, GT and EQ.
REQ-029 No other arithmetic comparison of in_data against max_val is permitted in max_tracker.

Verification
REQ-030 After rst, send samples 1, 0, 2, 2, 3 on consecutive cycles; the bench SHALL check the response below.
- max_val: 1, 1, 2, 2, 3.
- new_max: 1, 0, 1, 0, 1.
- eq_count: 1, 1, 1, 2, 1.
- state: MAXED after the last sample.
REQ-031 Send 20 consecutive samples of value 3; eq_count and sample_count SHALL stop at 15, and new_max SHALL pulse only on the first sample.
REQ-032 Send 2, then idle for 3 cycles, then send 1; max_val SHALL stay 2, eq_count SHALL stay 1, sample_count SHALL become 2, and new_max SHALL be 0 throughout after the first pulse.
REQ-033 Assert clear with in_valid = 1 and in_data = 3 while max_val = 1; the next edge SHALL give all outputs 0 and max_valid = 0.
REQ-034 Assert rst for 1 cycle mid-stream together with in_valid; all outputs SHALL be 0 on the next edge, and the following sample 0 SHALL give max_val = 0, max_valid = 1 and new_max = 1.
REQ-035 Exhaustive check: for every pair (max_val, in_data) in 0..3 x 0..3, new_max SHALL be 1 exactly when in_data > max_val, and eq_count SHALL increment exactly when the two are equal.
